// File: rtl/muldiv_unit_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_unit_pkg
// Shared definitions for the iterative multiply/divide unit:
//   - op encodings as driven on the unit's op input (MULT/MULTU/DIV/DIVU)
//   - FSM state encodings (IDLE, RUN, FIX)
//   - small helpers decoding the op field
// -----------------------------------------------------------------------------
package muldiv_unit_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_FIX  = 2'b10;

    // op[1] selects divide, op[0] selects the unsigned variant.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// One radix-2 iteration of the multiply/divide datapath (purely combinational).
//   is_div_i : 0 = shift-add multiply step, 1 = restoring divide step
//   upper_i  : product high half / partial remainder
//   lower_i  : product low half (multiplier bits) / quotient-dividend shift reg
//   opnd_i   : multiplicand magnitude / divisor magnitude
//   upper_o  : next upper word
//   lower_o  : next lower word
// -----------------------------------------------------------------------------
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] upper_i,
    input  logic [WIDTH-1:0] lower_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH-1:0] upper_o,
    output logic [WIDTH-1:0] lower_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        // NOTE: every output gets a default before any branch so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        upper_o = upper_i;
        lower_o = lower_i;

        // Multiply: add the multiplicand when the current multiplier bit is 1,
        // then shift the whole {carry, upper, lower} word right by one.
        sum = {1'b0, upper_i} + (lower_i[0] ? {1'b0, opnd_i} : '0);

        // Divide: bring the next dividend bit into the WIDTH+1 bit partial
        // remainder. The remainder is always below the divisor, so
        // shifted < 2*divisor and the difference fits a signed WIDTH+1 word;
        // its top bit is therefore the borrow.
        shifted = {upper_i, lower_i[WIDTH-1]};
        diff    = shifted - {1'b0, opnd_i};

        if (is_div_i) begin
            if (!diff[WIDTH]) begin
                upper_o = diff[WIDTH-1:0];
                lower_o = {lower_i[WIDTH-2:0], 1'b1};
            end else begin
                upper_o = shifted[WIDTH-1:0];
                lower_o = {lower_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            upper_o = sum[WIDTH:1];
            lower_o = {sum[0], lower_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
//   clk    : rising-edge clock
//   rst    : asynchronous active-low reset
//   start  : begin the op selected by op (accepted only in IDLE)
//   op     : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b   : rs / rt operands (only needed in the start cycle)
//   mthi   : write a into HI (IDLE only)
//   mtlo   : write a into LO (IDLE only)
//   hi, lo : HI / LO registers
//   busy   : operation in progress (WIDTH+1 cycles)
//   done   : one-cycle pulse in the cycle HI/LO are updated
// Operation: magnitudes are processed for WIDTH cycles in RUN, and the FIX
// cycle applies sign correction and writes HI/LO.
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int             CW        = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  CNT_INIT  = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(1);

    logic [1:0]       state_q,   state_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic [WIDTH-1:0] upper_q,   upper_d;
    logic [WIDTH-1:0] lower_q,   lower_d;
    logic [WIDTH-1:0] opnd_q,    opnd_d;
    logic             is_div_q,  is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             div0_q,    div0_d;
    logic [WIDTH-1:0] hi_q,      hi_d;
    logic [WIDTH-1:0] lo_q,      lo_d;

    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] step_upper;
    logic [WIDTH-1:0] step_lower;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (is_div_q),
        .upper_i  (upper_q),
        .lower_i  (lower_q),
        .opnd_i   (opnd_q),
        .upper_o  (step_upper),
        .lower_o  (step_lower)
    );

    // Operand magnitudes; the most negative value wraps to itself, which the
    // unsigned datapath then treats as 2^(WIDTH-1), giving the MIPS results.
    always_comb begin
        signed_op = op_is_signed(op);
        a_neg     = signed_op & a[WIDTH-1];
        b_neg     = signed_op & b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
    end

    // Sign correction of the finished magnitude result. A zero divisor forces
    // an all-ones quotient; the remainder is already |a| and regains a's sign,
    // so HI ends up as the raw dividend.
    always_comb begin
        prod_fix = neg_res_q ? -{upper_q, lower_q} : {upper_q, lower_q};
        quot_fix = div0_q ? '1 : (neg_res_q ? -lower_q : lower_q);
        rem_fix  = neg_rem_q ? -upper_q : upper_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        upper_d   = upper_q;
        lower_d   = lower_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            S_IDLE: begin
                if (mthi) hi_d = a;
                if (mtlo) lo_d = a;
                if (start) begin
                    state_d   = S_RUN;
                    cnt_d     = CNT_INIT;
                    is_div_d  = op_is_div(op);
                    neg_res_d = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d = a_neg;
                    div0_d    = op_is_div(op) && (b == '0);
                    upper_d   = '0;
                    // Divide shifts the dividend out of lower; multiply
                    // consumes multiplier bits from lower's LSB.
                    if (op_is_div(op)) begin
                        lower_d = a_mag;
                        opnd_d  = b_mag;
                    end else begin
                        lower_d = b_mag;
                        opnd_d  = a_mag;
                    end
                end
            end
            S_RUN: begin
                upper_d = step_upper;
                lower_d = step_lower;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == CNT_LAST) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            upper_q   <= '0;
            lower_q   <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            upper_q   <= upper_d;
            lower_q   <= lower_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_FIX);

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Directed bench for muldiv_unit. Expected {hi, lo} pairs are queued when an
// operation is launched and popped when the unit signals completion.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [63:0] sb_q[$];

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Called at the first falling edge after the start edge. Counts busy
    // cycles up to and including the done cycle, then compares HI/LO with the
    // scoreboard entry once they have updated.
    task automatic finish_op(input string tag);
        int          cycles;
        int          dones;
        logic [63:0] exp;
        cycles = 0;
        dones  = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy) cycles++;
            if (done) begin
                dones++;
                break;
            end
            @(negedge clk);
        end
        check({tag, " busy cycles"}, 64'(cycles), 64'd33);
        check({tag, " done seen"}, 64'(dones), 64'd1);
        @(negedge clk);
        exp = sb_q.pop_front();
        check({tag, " hi:lo"}, {hi, lo}, exp);
        check({tag, " idle after"}, {62'd0, busy, done}, 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] eh, input logic [31:0] el);
        sb_q.push_back({eh, el});
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        @(negedge clk);
        start = 1'b0;
        // Operands only matter in the start cycle.
        a     = $urandom;
        b     = $urandom;
        finish_op(tag);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] rp;
        int          dones;

        rst_n = 1'b0;
        start = 1'b0;
        op    = OP_MULT;
        a     = '0;
        b     = '0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        repeat (2) @(negedge clk);
        check("reset hi:lo", {hi, lo}, 64'd0);
        check("reset busy/done", {62'd0, busy, done}, 64'd0);
        rst_n = 1'b1;

        run_op("mult -3*7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("multu max*max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("divu by zero", OP_DIVU, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);
        run_op("div neg by zero", OP_DIV, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
        run_op("div overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

        for (int i = 0; i < 2; i++) begin
            ra = $urandom;
            rb = $urandom;
            rp = $signed({{32{ra[31]}}, ra}) * $signed({{32{rb[31]}}, rb});
            run_op($sformatf("mult rand%0d", i), OP_MULT, ra, rb, rp[63:32], rp[31:0]);
            ra = $urandom;
            rb = $urandom_range(1, 65535);
            run_op($sformatf("divu rand%0d", i), OP_DIVU, ra, rb, ra % rb, ra / rb);
        end

        // MTHI then MTLO in IDLE, then both together.
        @(negedge clk);
        mthi = 1'b1;
        a    = 32'hAAAA_5555;
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b1;
        a    = 32'h0000_1234;
        @(negedge clk);
        mtlo = 1'b0;
        check("mthi/mtlo", {hi, lo}, {32'hAAAA_5555, 32'h0000_1234});
        mthi = 1'b1;
        mtlo = 1'b1;
        a    = 32'hCAFE_F00D;
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b0;
        check("mthi+mtlo", {hi, lo}, {32'hCAFE_F00D, 32'hCAFE_F00D});

        // MTHI and a second start while busy are ignored.
        sb_q.push_back({32'd0, 32'd42});
        start = 1'b1;
        op    = OP_MULTU;
        a     = 32'd6;
        b     = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1;
        mthi  = 1'b1;
        op    = OP_DIVU;
        a     = 32'h5555;
        b     = 32'd3;
        @(negedge clk);
        start = 1'b0;
        mthi  = 1'b0;
        check("mthi ignored while busy", {32'd0, hi}, {32'd0, 32'hCAFE_F00D});
        dones = 0;
        for (int i = 0; i < 80; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        check("single done while busy", 64'(dones), 64'd1);
        check("busy-ignore hi:lo", {hi, lo}, sb_q.pop_front());
        check("busy-ignore idle", {63'd0, busy}, 64'd0);

        // MTHI in the same cycle as start: HI written now, result overwrites.
        sb_q.push_back({32'd0, 32'd6});
        start = 1'b1;
        mthi  = 1'b1;
        op    = OP_MULTU;
        a     = 32'd2;
        b     = 32'd3;
        @(negedge clk);
        start = 1'b0;
        mthi  = 1'b0;
        check("mthi with start", {32'd0, hi}, {32'd0, 32'd2});
        finish_op("multu after mthi");

        // Reset in the middle of an operation aborts it.
        start = 1'b1;
        op    = OP_MULT;
        a     = 32'd5;
        b     = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort hi:lo", {hi, lo}, 64'd0);
        check("abort busy/done", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) dones++;
            @(negedge clk);
        end
        check("no activity after abort", 64'(dones), 64'd0);
        run_op("mult 5*6 after reset", OP_MULT, 32'd5, 32'd6, 32'd0, 32'd30);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the MIPS EX stage.
- Executes MULT, MULTU, DIV and DIVU into architectural HI/LO registers, and services MTHI and MTLO.
- The hi/lo outputs feed the 3-input 32-bit writeback select mux, which serves MFHI/MFLO.
- busy stalls the pipeline while an operation runs.

Parameters:
- WIDTH, 32, operand/HI/LO width; counter width is clog2(WIDTH)+1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  begin operation selected by op; sampled only in IDLE
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  input  WIDTH  rs operand (multiplicand / dividend)
- b  input  WIDTH  rt operand (multiplier / divisor)
- mthi  input  1  write a into HI; honoured only in IDLE
- mtlo  input  1  write a into LO; honoured only in IDLE
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse in the cycle HI/LO update

Behaviour:
- Reset (rst=0, async): state=IDLE; hi=0, lo=0, busy=0, done=0; counter and working registers cleared.
- Reset asserted mid-operation aborts it. HI/LO return to 0. No done pulse.
- FSM states: IDLE, RUN, FIX.
- IDLE + start: latch magnitudes |a|, |b| (signed ops) or raw values (unsigned ops). Latch result-sign flags. counter=WIDTH. Go to RUN. busy=1 from the next cycle.
- RUN performs one radix-2 step per cycle:
  - Multiply: shift-add into a 2*WIDTH product.
  - Divide: restoring step on a WIDTH+1 partial remainder.
  - counter decrements. At counter=1 the step executes and the FSM goes to FIX.
- FIX: apply sign correction.
  - Product is negated if the signs of a and b differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
  - hi/lo update at this edge. done=1 for this one cycle. Next state is IDLE.
- Latency: start sampled at edge 0, then busy high for WIDTH+1 cycles (33). done coincides with the last busy cycle. New hi/lo are visible the cycle after done's edge.
- Multiply result: hi=product[2W-1:W], lo=product[W-1:0].
- Divide result: lo=quotient, hi=remainder.
- Divide by zero: lo=all ones, hi=dividend a (raw). Same 33-cycle latency.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This falls out of magnitude arithmetic with wrap.
- start while busy: ignored.
- mthi/mtlo while busy: ignored. The pipeline guarantees stall.
- start with mthi or mtlo in the same IDLE cycle: mthi/mtlo write this cycle, and the operation starts. The operation result later overwrites both HI and LO.
- mthi and mtlo together: both written with a.
- Operand inputs need only be valid in the start cycle.

Decomposition:
- Shared package holds:
  - op encodings OP_MULT=2'b00, OP_MULTU=2'b01, OP_DIV=2'b10, OP_DIVU=2'b11
  - state encoding S_IDLE, S_RUN, S_FIX
- One natural sub-module: muldiv_step. It is combinational: one shift-add or restore-subtract step, selected by a mul/div flag. The FSM/registers wrapper instantiates it.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7 -> after 33 busy cycles, done; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=0x0000000E, hi=0x00000002.
- DIVU a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0xAAAA5555 then MTLO a=0x1234 in IDLE -> hi=0xAAAA5555, lo=0x1234. Repeat MTHI and a second start during busy -> hi/lo keep the running op's result; only one done pulse.
- Start MULT 5*6, then drop rst to 0 at cycle 10 and release -> hi=lo=0, busy=0, no done. A fresh MULT 5*6 then gives lo=30, hi=0.
